fpu_seq: RTL and testbench

Multicycle sequencer for the FPU datapath path, i.e. the operand latches, the FPU core and the FPU writeback. The main controller hands it one FP instruction: add or mul, single or double precision. fpu_seq reads the operands through the register file, where a double occupies register pair Rn/Rn+1. It issues the operation to the variable-latency FPU core, waits for completion with a timeout, then writes the result back over one or two cycles. The main controller FSM stalls while busy=1.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_wait_timer.sv | 38 +++
 rtl/fpu_seq.sv | 146 ++++++++++++++
 tb/tb_fpu_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared encodings for the FPU instruction sequencer: FSM state
//             codes, FP operation codes and operand-latch one-hot selects.
//  Revision : 1.0  initial release
// ============================================================================
package fpu_pkg;

  // Sequencer states, 4-bit binary
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RA_LO = 4'd1,
    S_RA_HI = 4'd2,
    S_RB_LO = 4'd3,
    S_RB_HI = 4'd4,
    S_ISSUE = 4'd5,
    S_WAIT  = 4'd6,
    S_WB_LO = 4'd7,
    S_WB_HI = 4'd8,
    S_FIN   = 4'd9
  } state_t;

  // FP operation codes carried on op / fpu_op
  localparam logic FOP_ADD = 1'b0;
  localparam logic FOP_MUL = 1'b1;

  // Operand latch enables, bit order {b_hi, b_lo, a_hi, a_lo}
  localparam logic [3:0] LD_NONE = 4'b0000;
  localparam logic [3:0] LD_A_LO = 4'b0001;
  localparam logic [3:0] LD_A_HI = 4'b0010;
  localparam logic [3:0] LD_B_LO = 4'b0100;
  localparam logic [3:0] LD_B_HI = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/fpu_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_wait_timer
//  Purpose  : Wait-cycle counter for the FPU completion wait. Synchronous
//             clear, count enable, and a terminal flag at TIMEOUT-1.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_wait_timer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic reset,     // asynchronous, active-low
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: clear has priority over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + C_ONE;
    end
  end

  assign term_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/fpu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_seq
//  Purpose  : Multicycle sequencer for one FP add/mul instruction. Reads the
//             operands (register pairs for double), issues to the FPU core,
//             waits for completion with a timeout and writes the result back.
//             All outputs are decoded from registered state only.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic       start,
  input  logic       op,
  input  logic       dbl,
  output logic       rd_hi,
  output logic [3:0] ld_en,
  output logic       fpu_start,
  output logic       fpu_op,
  output logic       fpu_dbl,
  input  logic       fpu_done,
  output logic       fpu_write,
  output logic       wr_hi,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t state_q, state_d;
  logic   op_q, op_d;
  logic   dbl_q, dbl_d;
  logic   err_q, err_d;
  logic   tmr_clr, tmr_en, tmr_term;

  fpu_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_o (tmr_term)
  );

  // State and captured-instruction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      dbl_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dbl_q   <= dbl_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; fpu_done is only looked at in WAIT, start only in IDLE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dbl_d   = dbl_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          dbl_d   = dbl;
          err_d   = 1'b0;
          state_d = S_RA_LO;
        end
      end
      S_RA_LO: state_d = dbl_q ? S_RA_HI : S_RB_LO;
      S_RA_HI: state_d = S_RB_LO;
      S_RB_LO: state_d = dbl_q ? S_RB_HI : S_ISSUE;
      S_RB_HI: state_d = S_ISSUE;
      S_ISSUE: begin
        tmr_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats a simultaneous timeout
        if (fpu_done) begin
          state_d = S_WB_LO;
        end else if (tmr_term) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmr_en  = 1'b1;
        end
      end
      S_WB_LO: state_d = dbl_q ? S_WB_HI : S_FIN;
      S_WB_HI: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state
  always_comb begin
    ld_en     = LD_NONE;
    rd_hi     = 1'b0;
    fpu_start = 1'b0;
    fpu_write = 1'b0;
    wr_hi     = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_RA_LO: ld_en = LD_A_LO;
      S_RA_HI: begin
        ld_en = LD_A_HI;
        rd_hi = 1'b1;
      end
      S_RB_LO: ld_en = LD_B_LO;
      S_RB_HI: begin
        ld_en = LD_B_HI;
        rd_hi = 1'b1;
      end
      S_ISSUE: fpu_start = 1'b1;
      S_WB_LO: fpu_write = 1'b1;
      S_WB_HI: begin
        fpu_write = 1'b1;
        wr_hi     = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Captured op/dbl are presented only while an instruction is in flight
  assign fpu_op  = op_q  & busy;
  assign fpu_dbl = dbl_q & busy;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_seq
//  Purpose  : Self-checking bench for fpu_seq with a per-cycle expected-output
//             scoreboard built from the instruction timing rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpu_seq;
  import fpu_pkg::*;

  localparam int TO = 8;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic       dbl = 1'b0;
  logic       fpu_done = 1'b0;
  logic       rd_hi, fpu_start, fpu_op, fpu_dbl, fpu_write, wr_hi, busy, done, err;
  logic [3:0] ld_en;

  fpu_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .dbl       (dbl),
    .rd_hi     (rd_hi),
    .ld_en     (ld_en),
    .fpu_start (fpu_start),
    .fpu_op    (fpu_op),
    .fpu_dbl   (fpu_dbl),
    .fpu_done  (fpu_done),
    .fpu_write (fpu_write),
    .wr_hi     (wr_hi),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Output vector order: {ld_en, rd_hi, fpu_start, fpu_op, fpu_dbl, fpu_write, wr_hi, busy, done, err}
  logic [12:0] obs;
  assign obs = {ld_en, rd_hi, fpu_start, fpu_op, fpu_dbl, fpu_write, wr_hi, busy, done, err};

  typedef struct {
    logic [12:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [12:0] mk(logic [3:0] ld, logic rh, logic fs, logic fo, logic fd,
                                     logic fw, logic wh, logic b, logic d, logic e);
    return {ld, rh, fs, fo, fd, fw, wh, b, d, e};
  endfunction

  task automatic push(input logic [12:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask

  // One instruction: push the expected output for every cycle, drive inputs.
  // L = cycles from ISSUE to fpu_done; L > TO means fpu_done never comes.
  task automatic run_op(input logic op_v, input logic dbl_v, input int L, input bit spur,
                        input bit st_wait, input int abort_at, input string name);
    int         nrd, iss, wend, fin, last;
    bit         to;
    logic [3:0] ld;
    logic       rh;
    nrd  = dbl_v ? 4 : 2;
    iss  = nrd + 1;
    to   = (L > TO);
    wend = to ? iss + TO : iss + L;
    fin  = wend + (to ? 0 : (dbl_v ? 2 : 1)) + 1;
    last = (abort_at > 0) ? abort_at : fin;
    start = 1'b1;
    op    = op_v;
    dbl   = dbl_v;
    for (int c = 1; c <= last; c++) begin
      ld = LD_NONE;
      rh = 1'b0;
      if (c <= nrd) begin
        case (c)
          1:       ld = LD_A_LO;
          2:       ld = dbl_v ? LD_A_HI : LD_B_LO;
          3:       ld = LD_B_LO;
          default: ld = LD_B_HI;
        endcase
        rh = dbl_v && (c == 2 || c == 4);
      end
      push(mk(ld, rh, c == iss, op_v, dbl_v, !to && c > wend && c < fin,
              dbl_v && !to && c == wend + 2, 1'b1, c == fin, to && c == fin),
           $sformatf("%s_c%0d", name, c));
      tick();
      start    = st_wait && (c == iss + 1);
      op       = 1'($urandom);
      dbl      = 1'($urandom);
      fpu_done = (!to && c == iss + L) || (spur && c == (dbl_v ? 3 : 2));
    end
    start    = 1'b0;
    fpu_done = 1'b0;
    if (abort_at > 0) begin
      #2 reset = 1'b0;
      #1;
      push('0, {name, "_async"});
      check();
      push('0, {name, "_hold"});
      tick();
      #2 reset = 1'b1;
    end
    push(mk(LD_NONE, 0, 0, 0, 0, 0, 0, 0, 0, (abort_at == 0) && to), {name, "_idle"});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push('0, "reset_state");
    check();
    #2 reset = 1'b1;

    run_op(FOP_ADD, 1'b0, 3,  1'b0, 1'b0, 0, "sgl_add");
    run_op(FOP_MUL, 1'b1, 1,  1'b0, 1'b0, 0, "dbl_mul");
    run_op(FOP_ADD, 1'b0, 99, 1'b0, 1'b0, 0, "timeout");
    run_op(FOP_MUL, 1'b0, 4,  1'b1, 1'b1, 0, "spurious");
    run_op(FOP_ADD, 1'b1, TO, 1'b0, 1'b0, 0, "coincide");
    run_op(FOP_MUL, 1'b1, 99, 1'b0, 1'b0, 0, "dbl_timeout");
    run_op(FOP_MUL, 1'b1, 5,  1'b1, 1'b0, 7, "reset_mid");
    run_op(FOP_ADD, 1'b0, 2,  1'b0, 1'b0, 0, "after_reset");
    run_op(FOP_MUL, 1'b1, 7,  1'b1, 1'b1, 0, "dbl_late");

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
